// File: rtl/tdm_demux8.sv
// tdm_demux8 - registered 1-to-8 time-division demultiplexer.
//
// Receive end of the 8:1 TDM path. Each valid beat carries one WIDTH-bit
// sample. A beat flagged with SOF starts a frame as channel 0, and the next
// seven beats fill channels 1..7 in order. The eight slots are collected in a
// shadow buffer and published to Y in one step when the eighth beat lands.
// Partial frames never reach Y.
//
// Optional feature macro: TDM_GAP_TIMEOUT_EN
//   When it is defined, an idle counter aborts a partial frame after TIMEOUT
//   consecutive V=0 cycles in FILL.
//
// Parameters:
//   WIDTH       bits per channel sample
//   TIMEOUT     idle cycles tolerated inside a frame (TDM_GAP_TIMEOUT_EN only)
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   D           sample data, qualified by V
//   V           beat valid
//   SOF         start-of-frame, meaningful only when V=1
//   Y           published frame; channel k at Y[k*WIDTH +: WIDTH]
//   S           next channel slot to be written
//   FRAME_DONE  one-cycle pulse when Y updates
//   OUT_VALID   high once at least one frame has been published
//   ERR         one-cycle pulse on a protocol error (orphan beat, early SOF,
//               gap timeout)

module tdm_demux8 #(
  parameter int WIDTH   = 1,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     D,
  input  logic                 V,
  input  logic                 SOF,
  output logic [8*WIDTH-1:0]   Y,
  output logic [2:0]           S,
  output logic                 FRAME_DONE,
  output logic                 OUT_VALID,
  output logic                 ERR
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   shadow [8];
  logic [8*WIDTH-1:0] next_frame;

`ifdef TDM_GAP_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  logic [IDLE_W-1:0] idle_cnt;
`else
  // TIMEOUT has no effect when the gap counter is not built.
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Frame as it will look once the eighth beat lands. Slot 7 comes straight
  // from D, so the beat sampled on the completing edge is part of the frame.
  always_comb begin
    next_frame = '0;
    for (int k = 0; k < 7; k++) begin
      next_frame[k*WIDTH +: WIDTH] = shadow[k];
    end
    next_frame[7*WIDTH +: WIDTH] = D;
  end

  // Frame capture FSM. FRAME_DONE and ERR default low each cycle so they can
  // only be single-cycle pulses. One beat either completes a frame or raises an
  // error, never both, so the two pulses cannot overlap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      Y          <= '0;
      S          <= 3'd0;
      FRAME_DONE <= 1'b0;
      OUT_VALID  <= 1'b0;
      ERR        <= 1'b0;
      for (int k = 0; k < 8; k++) begin
        shadow[k] <= '0;
      end
`ifdef TDM_GAP_TIMEOUT_EN
      idle_cnt   <= '0;
`endif
    end else begin
      FRAME_DONE <= 1'b0;
      ERR        <= 1'b0;
`ifdef TDM_GAP_TIMEOUT_EN
      if (V || state == IDLE) begin
        idle_cnt <= '0;
      end
`endif
      case (state)
        IDLE: begin
          if (V) begin
            if (SOF) begin
              shadow[0] <= D;
              S         <= 3'd1;
              state     <= FILL;
            end else begin
              // A beat with no frame open is dropped.
              ERR <= 1'b1;
            end
          end
        end

        FILL: begin
          if (V) begin
            if (SOF) begin
              // An early SOF drops the partial frame and restarts at slot 0.
              // The stale slots need no clearing because they are rewritten
              // before the frame can be published.
              ERR       <= 1'b1;
              shadow[0] <= D;
              S         <= 3'd1;
            end else begin
              shadow[S] <= D;
              if (S == 3'd7) begin
                Y          <= next_frame;
                FRAME_DONE <= 1'b1;
                OUT_VALID  <= 1'b1;
                S          <= 3'd0;
                state      <= IDLE;
              end else begin
                S <= S + 3'd1;
              end
            end
          end else begin
`ifdef TDM_GAP_TIMEOUT_EN
            // The TIMEOUT-th consecutive idle cycle aborts the frame. Y keeps
            // the last complete frame.
            if (idle_cnt == IDLE_W'(TIMEOUT - 1)) begin
              ERR      <= 1'b1;
              S        <= 3'd0;
              state    <= IDLE;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
`endif
          end
        end

        default: begin
          state <= IDLE;
          S     <= 3'd0;
        end
      endcase
    end
  end

endmodule
